// File: rtl/i2c_tb_pkg.sv
// Shared types and constants for the I2C responder with register file.
package i2c_tb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR,
    WR_ACK,
    RD,
    RD_ACK,
    IGNORE
  } resp_state_t;

  localparam logic I2C_RW_READ = 1'b1;
  localparam logic I2C_ACK     = 1'b0;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchroniser for the resolved SCL/SDA pins plus edge and START/STOP detection.
// SCL and SDA go through identical chains, so their relative order is preserved.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sr;
  logic [SYNC_STAGES-1:0] sda_sr;
  logic                   scl_q;
  logic                   sda_q;

  // Synchroniser chains, idle-high, followed by one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sr <= '1;
      sda_sr <= '1;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl_i};
      sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_i};
      scl_q  <= scl_sr[SYNC_STAGES-1];
      sda_q  <= sda_sr[SYNC_STAGES-1];
    end
  end

  assign scl       = scl_sr[SYNC_STAGES-1];
  assign sda       = sda_sr[SYNC_STAGES-1];
  assign scl_rise  = scl & ~scl_q;
  assign scl_fall  = ~scl & scl_q;
  // SDA edges only count as START/STOP while SCL is stable high
  assign start_det = scl & scl_q & sda_q & ~sda;
  assign stop_det  = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/i2c_responder_regfile.sv
// I2C target with a DEPTH-entry register file, auto-incrementing pointer and
// optional SCL stretching after every ACK slot.
module i2c_responder_regfile
  import i2c_tb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR       = 7'h50,
  parameter int         DEPTH          = 16,
  parameter int         STRETCH_CYCLES = 0,
  parameter int         SYNC_STAGES    = 2,
  localparam int        PTR_W          = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             scl_o,
  output logic             sda_o,
  input  logic             cfg_we,
  input  logic [PTR_W-1:0] cfg_addr,
  input  logic [7:0]       cfg_data,
  output logic             wr_stb,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);

  localparam int SW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES + 1) : 1;
  localparam logic [SW-1:0] STR_INIT = SW'((STRETCH_CYCLES > 0) ? STRETCH_CYCLES - 1 : 0);

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl       (scl_s),
    .sda       (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  resp_state_t      state, state_n;
  logic [3:0]       cnt, cnt_n;        // SCL rising edges seen in the current byte
  logic [7:0]       sh, sh_n;
  logic [PTR_W-1:0] ptr, ptr_n, ptr_inc;
  logic [SW-1:0]    str_cnt, str_n;
  logic             sda_n, scl_n, busy_n, rw, rw_n, mack, mack_n, pdone, pdone_n;
  logic             wr_stb_n, commit, stretch;
  logic [PTR_W-1:0] wr_addr_n;
  logic [7:0]       wr_data_n;
  logic [7:0]       regs [DEPTH];

  assign ptr_inc = ptr + 1'b1;   // natural wrap, DEPTH is a power of two

  // State and output registers; lines are released in the same edge as reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      ptr     <= '0;
      str_cnt <= '0;
      sda_o   <= 1'b1;
      scl_o   <= 1'b1;
      busy    <= 1'b0;
      rw      <= 1'b0;
      mack    <= 1'b1;
      pdone   <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sh      <= sh_n;
      ptr     <= ptr_n;
      str_cnt <= str_n;
      sda_o   <= sda_n;
      scl_o   <= scl_n;
      busy    <= busy_n;
      rw      <= rw_n;
      mack    <= mack_n;
      pdone   <= pdone_n;
      wr_stb  <= wr_stb_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
    end
  end

  // Next-state logic: bit shifting, ACK slots, pointer handling and stretch control
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sh_n      = sh;
    ptr_n     = ptr;
    str_n     = str_cnt;
    sda_n     = sda_o;
    scl_n     = scl_o;
    busy_n    = busy;
    rw_n      = rw;
    mack_n    = mack;
    pdone_n   = pdone;
    wr_stb_n  = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    commit    = 1'b0;
    stretch   = 1'b0;

    // count down an active stretch while the bus is seen low
    if (!scl_o && !scl_s) begin
      if (str_cnt == '0) scl_n = 1'b1;
      else               str_n = str_cnt - 1'b1;
    end

    if (stop_det) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      sda_n   = 1'b1;
      scl_n   = 1'b1;
    end else if (start_det) begin
      state_n = ADDR;
      cnt_n   = '0;
      sda_n   = 1'b1;
      scl_n   = 1'b1;
      pdone_n = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WR: begin
          if (scl_rise && cnt != 4'd8) begin
            sh_n  = {sh[6:0], sda_s};
            cnt_n = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            sda_n = 1'b0;
            if (state == ADDR) begin
              if (sh[7:1] == DEV_ADDR) begin
                state_n = ADDR_ACK;
                busy_n  = 1'b1;
                rw_n    = sh[0];
              end else begin
                state_n = IGNORE;
                sda_n   = 1'b1;
              end
            end else if (state == PTR) begin
              state_n = PTR_ACK;
              ptr_n   = sh[PTR_W-1:0];
              pdone_n = 1'b1;
            end else begin
              state_n = WR_ACK;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          cnt_n   = '0;
          stretch = 1'b1;
          if (rw == I2C_RW_READ) begin
            state_n = RD;
            sh_n    = regs[ptr];
            sda_n   = regs[ptr][7];
          end else begin
            state_n = pdone ? WR : PTR;
            sda_n   = 1'b1;
          end
        end
        PTR_ACK: if (scl_fall) begin
          state_n = WR;
          cnt_n   = '0;
          sda_n   = 1'b1;
          stretch = 1'b1;
        end
        WR_ACK: begin
          if (scl_rise) begin
            commit    = 1'b1;
            wr_stb_n  = 1'b1;
            wr_addr_n = ptr;
            wr_data_n = sh;
            ptr_n     = ptr_inc;
          end else if (scl_fall) begin
            state_n = WR;
            cnt_n   = '0;
            sda_n   = 1'b1;
            stretch = 1'b1;
          end
        end
        RD: begin
          if (scl_rise && cnt != 4'd8) begin
            cnt_n = cnt + 4'd1;
          end else if (scl_fall) begin
            if (cnt == 4'd8) begin
              state_n = RD_ACK;
              sda_n   = 1'b1;
            end else if (cnt != 4'd0) begin
              sh_n  = {sh[6:0], 1'b0};
              sda_n = sh[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            mack_n = sda_s;
          end else if (scl_fall) begin
            if (mack == I2C_ACK) begin
              state_n = RD;
              cnt_n   = '0;
              ptr_n   = ptr_inc;
              sh_n    = regs[ptr_inc];
              sda_n   = regs[ptr_inc][7];
              stretch = 1'b1;
            end else begin
              state_n = IGNORE;
              sda_n   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    if (stretch && STRETCH_CYCLES > 0) begin
      scl_n = 1'b0;
      str_n = STR_INIT;
    end
  end

  // Register file: cfg preload, then the I2C commit so it wins same-index collisions
  always_ff @(posedge clk) begin
    if (cfg_we) regs[cfg_addr] <= cfg_data;
    if (commit && rst_n) regs[ptr] <= sh;
  end

endmodule

// File: tb/tb_i2c_responder_regfile.sv
// Bench: bit-banged I2C master, directed vector table, randomized transfers
// against an array/pointer model, plus stretch, mismatch and reset sequences.
module tb_i2c_responder_regfile;

  localparam int DEPTH = 16;
  localparam int Q     = 3;
  localparam int STR   = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       scl_o, sda_o, wr_stb, busy;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0, wr_addr;
  logic [7:0] cfg_data = '0, wr_data;
  wire        scl_bus = scl_m & scl_o;
  wire        sda_bus = sda_m & sda_o;

  always #5 clk = ~clk;

  i2c_responder_regfile #(
    .DEV_ADDR(7'h50), .DEPTH(DEPTH), .STRETCH_CYCLES(STR), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_bus), .sda_i(sda_bus),
    .scl_o(scl_o), .sda_o(sda_o), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy)
  );

  int npass = 0, ntot = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // observation monitors
  logic [11:0] wq[$];
  int run = 0, sda_low = 0, busy_hi = 0;
  bit ign_run = 1'b0;
  always @(negedge clk) begin
    if (wr_stb) wq.push_back({wr_addr, wr_data});
    if (!sda_o) sda_low++;
    if (busy) busy_hi++;
    if (!scl_o) run++;
    else if (run != 0) begin
      if (!ign_run) chk("stretch_len", run, STR);
      run = 0;
    end
  end

  // reference model
  logic [7:0] mregs [DEPTH];
  int         mptr = 0;
  logic [7:0] tx_buf [4], rx_buf [4], exp_d [4];
  int         exp_a [4];

  function automatic void model_xfer(input bit rd, input bit set_ptr, input int p, input int n);
    if (!rd || set_ptr) mptr = p % DEPTH;
    for (int i = 0; i < n; i++) begin
      if (!rd) begin
        exp_a[i] = mptr; exp_d[i] = tx_buf[i];
        mregs[mptr] = tx_buf[i];
        mptr = (mptr + 1) % DEPTH;
      end else begin
        exp_d[i] = mregs[mptr];
        if (i < n - 1) mptr = (mptr + 1) % DEPTH;
      end
    end
  endfunction

  // bus master primitives
  int last_wait;
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scl_rel();
    scl_m = 1'b1; last_wait = 0; #1;
    while (!scl_bus && last_wait < 200) begin @(posedge clk); #1; last_wait++; end
    if (!scl_bus) chk("scl_release_timeout", 0, 1);
  endtask

  task automatic send_bit(input logic b, output logic s);
    cyc(Q); sda_m = b; cyc(Q); scl_rel(); s = sda_bus; cyc(2*Q); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; cyc(2*Q); scl_rel(); cyc(Q); sda_m = 1'b0; cyc(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    cyc(Q); sda_m = 1'b0; cyc(Q); scl_rel(); cyc(Q); sda_m = 1'b1; cyc(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    ack = (s == 1'b0);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin send_bit(1'b1, s); d[i] = s; end
    send_bit(nack, s);
  endtask

  task automatic cfg_wr(input int a, input logic [7:0] d);
    cfg_addr = 4'(a); cfg_data = d; cfg_we = 1'b1; cyc(1); cfg_we = 1'b0;
    mregs[a] = d;
  endtask

  task automatic do_xfer(input bit rd, input bit set_ptr, input int p, input int n);
    logic ack;
    wq.delete();
    if (!rd || set_ptr) begin
      i2c_start();
      send_byte(8'hA0, ack); chk("addr_w_ack", ack, 1); chk("busy_mid", busy, 1);
      send_byte(p[7:0], ack); chk("ptr_ack", ack, 1);
    end
    if (!rd) begin
      for (int i = 0; i < n; i++) begin send_byte(tx_buf[i], ack); chk("data_ack", ack, 1); end
    end else begin
      i2c_start();
      send_byte(8'hA1, ack); chk("addr_r_ack", ack, 1); chk("busy_mid", busy, 1);
      for (int i = 0; i < n; i++) recv_byte(i == n - 1, rx_buf[i]);
    end
    i2c_stop(); cyc(3);
    chk("busy_after_stop", busy, 0);
    if (rd) chk("rd_no_wr_stb", wq.size(), 0);
    else    chk("wr_stb_count", wq.size(), n);
  endtask

  task automatic cmp_model(input bit rd, input int n);
    for (int i = 0; i < n; i++) begin
      if (rd) chk("rd_data", rx_buf[i], exp_d[i]);
      else if (i < wq.size()) begin
        chk("wr_addr", wq[i][11:8], exp_a[i]);
        chk("wr_data", wq[i][7:0], exp_d[i]);
      end
    end
  endtask

  typedef struct {
    bit         rd;
    logic [7:0] p;
    logic [7:0] d0, d1;
    logic [3:0] a0, a1;
  } vec_t;
  vec_t tbl [4];

  initial begin
    logic ack, s, found;
    tbl[0] = '{1'b0, 8'h03, 8'h5A, 8'hC3, 4'd3,  4'd4};
    tbl[1] = '{1'b0, 8'h0F, 8'h11, 8'h22, 4'd15, 4'd0};
    tbl[2] = '{1'b1, 8'h0F, 8'h11, 8'h22, 4'd0,  4'd0};
    tbl[3] = '{1'b1, 8'h07, 8'h81, 8'h7E, 4'd0,  4'd0};

    // reset values
    cyc(5);
    chk("rst_scl_o", scl_o, 1); chk("rst_sda_o", sda_o, 1);
    chk("rst_wr_stb", wr_stb, 0); chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0); chk("rst_busy", busy, 0);
    rst_n = 1'b1; cyc(2);

    for (int i = 0; i < DEPTH; i++) cfg_wr(i, 8'($urandom_range(0, 255)));
    cfg_wr(7, 8'h81); cfg_wr(8, 8'h7E);

    // directed vectors
    for (int i = 0; i < 4; i++) begin
      tx_buf[0] = tbl[i].d0; tx_buf[1] = tbl[i].d1;
      model_xfer(tbl[i].rd, 1'b1, int'(tbl[i].p), 2);
      do_xfer(tbl[i].rd, 1'b1, int'(tbl[i].p), 2);
      if (tbl[i].rd) begin
        chk("tbl_rd0", rx_buf[0], tbl[i].d0);
        chk("tbl_rd1", rx_buf[1], tbl[i].d1);
      end else if (wq.size() == 2) begin
        chk("tbl_wr0", wq[0], {tbl[i].a0, tbl[i].d0});
        chk("tbl_wr1", wq[1], {tbl[i].a1, tbl[i].d1});
      end
      cmp_model(tbl[i].rd, 2);
    end

    // clock stretch: the first pointer bit's high phase must be held off
    i2c_start();
    send_byte(8'hA0, ack); chk("str_addr_ack", ack, 1);
    send_bit(1'b0, s);
    chk("scl_high_delayed", (last_wait >= 1), 1);
    for (int i = 0; i < 7; i++) send_bit(1'b0, s);
    send_bit(1'b1, s); chk("str_ptr_ack", s, 0);
    i2c_stop(); cyc(3);
    mptr = 0;

    // address mismatch
    sda_low = 0; busy_hi = 0; wq.delete();
    i2c_start();
    send_byte(8'hA2, ack); chk("mm_addr_nack", ack, 0);
    send_byte(8'h11, ack); chk("mm_data_nack", ack, 0);
    i2c_stop(); cyc(3);
    chk("mm_sda_low", sda_low, 0); chk("mm_busy", busy_hi, 0); chk("mm_wr_stb", wq.size(), 0);

    // randomized transfers
    for (int it = 0; it < 24; it++) begin
      int kind, n, p;
      kind = $urandom_range(0, 2);
      n = $urandom_range(1, 4);
      p = $urandom_range(0, 255);
      for (int i = 0; i < 4; i++) tx_buf[i] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) cfg_wr($urandom_range(0, DEPTH - 1), 8'($urandom_range(0, 255)));
      model_xfer(kind != 0, kind == 1, p, n);
      do_xfer(kind != 0, kind == 1, p, n);
      cmp_model(kind != 0, n);
    end

    // reset while both lines are held low in a read
    cfg_wr(5, 8'h12);
    i2c_start();
    send_byte(8'hA0, ack); chk("rr_addr_ack", ack, 1);
    send_byte(8'h05, ack); chk("rr_ptr_ack", ack, 1);
    i2c_start();
    send_byte(8'hA1, ack); chk("rr_rd_ack", ack, 1);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (!sda_o && !scl_o) found = 1'b1;
    end
    chk("rr_lines_low", found, 1);
    ign_run = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rr_sda_rel", sda_o, 1); chk("rr_scl_rel", scl_o, 1); chk("rr_busy", busy, 0);
    rst_n = 1'b1; cyc(2); ign_run = 1'b0;
    i2c_stop(); cyc(3);
    mptr = 0;
    model_xfer(1'b1, 1'b0, 0, 1);
    do_xfer(1'b1, 1'b0, 0, 1);
    cmp_model(1'b1, 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
